// File: rtl/mul_seq.sv
// Iterative shift-add multiplier/accumulator feeding the 40-bit MR register, with optional rounding.
// Build option: define MUL_SAT_EN to saturate MR on accumulate overflow or rounding carry-out.
module mul_seq #(
  parameter int unsigned SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SIZE-1:0]       op_a,
  input  logic [SIZE-1:0]       op_b,
  input  logic                  ps_mul_sgn,
  input  logic                  ps_mul_IbF,
  input  logic                  ps_mul_rndPrdt,
  input  logic [1:0]            ps_mul_op,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE*5/2-1:0]   mr_out,
  output logic                  mv
);
  localparam int unsigned MW = SIZE * 5 / 2;
  localparam int unsigned PW = 2 * SIZE;
  localparam int unsigned CW = $clog2(SIZE);
  localparam int unsigned UW = MW - SIZE;
`ifdef MUL_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam logic [MW-1:0] MR_MAX = {1'b0, {(MW-1){1'b1}}};
  localparam logic [MW-1:0] MR_MIN = {1'b1, {(MW-1){1'b0}}};
  localparam logic [UW-1:0] UP_MAX = {1'b0, {(UW-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, MUL, ACC, RND} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]   cnt;
  logic            sgn_q, ibf_q, rnd_q, neg_q, clr_pend;
  logic [1:0]      op_q;
  logic [PW-1:0]   mcand, prod;
  logic [SIZE-1:0] mplier;
  logic [MW-1:0]   acc, mr;
  logic            acc_ovf, acc_sat, mv_q, done_q;

  logic            accept, clr_req;
  logic [SIZE-1:0] a_abs, b_abs;
  logic [PW-1:0]   p_sgn, p_al;
  logic [MW-1:0]   p_ext, sum, diff, acc_nxt, res;
  logic            ovf, inc, rnd_ovf, rnd_sat;
  logic [UW-1:0]   upper, upper_r;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    clr_req   = 1'b0;
    case (state)
      IDLE: if (start && !clr_pend) begin
        if (ps_mul_op == 2'b11) clr_req = 1'b1;
        else begin
          accept    = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL:     if (cnt == CW'(SIZE - 1)) state_nxt = ACC;
      ACC:     state_nxt = RND;
      RND:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign done   = done_q;
  assign mr_out = mr;
  assign mv     = mv_q;

  always_comb begin
    a_abs = (ps_mul_sgn && op_a[SIZE-1]) ? -op_a : op_a;
    b_abs = (ps_mul_sgn && op_b[SIZE-1]) ? -op_b : op_b;
  end

  // Sign/alignment happen in product width before extension, so a fractional
  // 0x8000 x 0x8000 wraps negative exactly as the combinational path did.
  always_comb begin
    p_sgn   = neg_q ? -prod : prod;
    p_al    = ibf_q ? {p_sgn[PW-2:0], 1'b0} : p_sgn;
    p_ext   = sgn_q ? {{(MW-PW){p_al[PW-1]}}, p_al} : {{(MW-PW){1'b0}}, p_al};
    sum     = mr + p_ext;
    diff    = mr - p_ext;
    acc_nxt = p_ext;
    ovf     = 1'b0;
    case (op_q)
      2'b01: begin
        acc_nxt = sum;
        ovf     = (mr[MW-1] == p_ext[MW-1]) && (sum[MW-1] != mr[MW-1]);
      end
      2'b10: begin
        acc_nxt = diff;
        ovf     = (mr[MW-1] != p_ext[MW-1]) && (diff[MW-1] != mr[MW-1]);
      end
      default: ;
    endcase
    if (SAT_EN && ovf) acc_nxt = mr[MW-1] ? MR_MIN : MR_MAX;
  end

  always_comb begin
    upper   = acc[MW-1:SIZE];
    inc     = acc[SIZE-1] && ((acc[SIZE-2:0] != '0) || acc[SIZE]);
    upper_r = upper + UW'(inc);
    rnd_ovf = inc && (upper == UP_MAX);
    rnd_sat = 1'b0;
    res     = acc;
    if (rnd_q) begin
      if (acc_sat) res = {upper, {SIZE{1'b0}}};
      else if (SAT_EN && rnd_ovf) begin
        res     = MR_MAX;
        rnd_sat = 1'b1;
      end else res = {upper_r, {SIZE{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      sgn_q    <= 1'b0;
      ibf_q    <= 1'b0;
      rnd_q    <= 1'b0;
      neg_q    <= 1'b0;
      op_q     <= '0;
      clr_pend <= 1'b0;
      mcand    <= '0;
      mplier   <= '0;
      prod     <= '0;
      acc      <= '0;
      acc_ovf  <= 1'b0;
      acc_sat  <= 1'b0;
      mr       <= '0;
      mv_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      if (clr_pend) begin
        mr       <= '0;
        mv_q     <= 1'b0;
        done_q   <= 1'b1;
        clr_pend <= 1'b0;
      end
      if (clr_req) clr_pend <= 1'b1;
      if (accept) begin
        sgn_q  <= ps_mul_sgn;
        ibf_q  <= ps_mul_IbF;
        rnd_q  <= ps_mul_IbF && ps_mul_rndPrdt;
        op_q   <= ps_mul_op;
        neg_q  <= ps_mul_sgn && (op_a[SIZE-1] ^ op_b[SIZE-1]);
        mcand  <= {{SIZE{1'b0}}, a_abs};
        mplier <= b_abs;
        prod   <= '0;
        cnt    <= '0;
      end
      case (state)
        MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= {mcand[PW-2:0], 1'b0};
          mplier <= {1'b0, mplier[SIZE-1:1]};
          cnt    <= (cnt == CW'(SIZE - 1)) ? '0 : cnt + CW'(1);
        end
        ACC: begin
          acc     <= acc_nxt;
          acc_ovf <= ovf;
          acc_sat <= SAT_EN && ovf;
        end
        RND: begin
          mr     <= res;
          mv_q   <= mv_q | acc_ovf | rnd_sat;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: arithmetic reference model, directed corner cases and random ops.
module tb_mul_seq;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [15:0] op_a = '0, op_b = '0;
  logic        ps_mul_sgn = 1'b0, ps_mul_IbF = 1'b0, ps_mul_rndPrdt = 1'b0;
  logic [1:0]  ps_mul_op = '0;
  logic        busy, done, mv;
  logic [39:0] mr_out;

  int compared = 0, mismatched = 0;

  typedef struct packed {logic [39:0] mr; logic mv;} exp_t;
  exp_t   exp_q[$];
  exp_t   mon_e;
  longint m_mr = 0;
  bit     m_mv = 1'b0;

  localparam longint MAXV = 64'sd549755813887;
  localparam longint MINV = -64'sd549755813888;
`ifdef MUL_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  mul_seq #(.SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
    .ps_mul_sgn(ps_mul_sgn), .ps_mul_IbF(ps_mul_IbF), .ps_mul_rndPrdt(ps_mul_rndPrdt),
    .ps_mul_op(ps_mul_op), .busy(busy), .done(done), .mr_out(mr_out), .mv(mv)
  );

  always #5 clk = ~clk;

  function automatic longint wrap40(input longint v);
    longint w;
    w = v & 64'hFF_FFFF_FFFF;
    if (w > MAXV) w = w - 64'sd1099511627776;
    return w;
  endfunction

  // Reference: plain integer multiply, then MR arithmetic on 64-bit integers.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input bit sgn, input bit ibf, input bit rnd, input logic [1:0] op);
    longint ai, bi, p, r, q, frac;
    logic [31:0] p32;
    bit sat;
    if (op == 2'b11) begin
      m_mr = 0;
      m_mv = 1'b0;
      return;
    end
    ai  = sgn ? longint'($signed(a)) : longint'(a);
    bi  = sgn ? longint'($signed(b)) : longint'(b);
    p   = ai * bi;
    if (ibf) p = p * 2;
    p32 = p[31:0];
    p   = sgn ? longint'($signed(p32)) : longint'(p32);
    case (op)
      2'b01:   r = m_mr + p;
      2'b10:   r = m_mr - p;
      default: r = p;
    endcase
    sat = 1'b0;
    if (r > MAXV || r < MINV) begin
      m_mv = 1'b1;
      if (SAT) begin
        r   = (r > MAXV) ? MAXV : MINV;
        sat = 1'b1;
      end else r = wrap40(r);
    end
    if (ibf && rnd) begin
      if (sat) r = r & ~64'hFFFF;
      else begin
        q    = r >>> 16;
        frac = r & 64'hFFFF;
        if (frac > 32768 || (frac == 32768 && q[0])) q = q + 1;
        r = q * 65536;
        if (r > MAXV) begin
          if (SAT) begin
            r    = MAXV;
            m_mv = 1'b1;
          end else r = wrap40(r);
        end
      end
    end
    m_mr = r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_done: mr_out=%h mv=%b with no result due", mr_out, mv);
      end else begin
        mon_e = exp_q.pop_front();
        if (mr_out !== mon_e.mr || mv !== mon_e.mv) begin
          mismatched++;
          $display("FAIL result: mr_out=%h mv=%b expected mr_out=%h mv=%b",
                   mr_out, mv, mon_e.mr, mon_e.mv);
        end
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit sgn,
                        input bit ibf, input bit rnd, input logic [1:0] op,
                        input bit chk, input logic [39:0] exp_mr, input int pulse_at);
    int   n;
    exp_t e;
    model(a, b, sgn, ibf, rnd, op);
    e.mr = m_mr[39:0];
    e.mv = m_mv;
    exp_q.push_back(e);
    op_a = a; op_b = b; ps_mul_sgn = sgn; ps_mul_IbF = ibf;
    ps_mul_rndPrdt = rnd; ps_mul_op = op; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == pulse_at) begin
        start = 1'b1; ps_mul_op = 2'b11; op_a = 16'h1234;
      end else start = 1'b0;
    end
    check("latency", 64'(n), (op == 2'b11) ? 64'd1 : 64'd18);
    if (chk) check("mr_value", 64'(mr_out), 64'(exp_mr));
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    logic [1:0] rop;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_mv", 64'(mv), 0);
    check("rst_mr", 64'(mr_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'h0003, 16'hFFFB, 1, 0, 0, 2'b00, 1, 40'hFF_FFFF_FFF1, -1);
    run_op(16'h4000, 16'h4000, 1, 1, 0, 2'b00, 1, 40'h00_2000_0000, -1);
    run_op(16'h0001, 16'h4000, 1, 1, 1, 2'b00, 1, 40'h00_0000_0000, -1);
    run_op(16'h0003, 16'h4000, 1, 1, 1, 2'b00, 1, 40'h00_0002_0000, -1);
    run_op(16'h0001, 16'h6000, 1, 1, 1, 2'b00, 1, 40'h00_0001_0000, -1);
    run_op(16'hFFFF, 16'hFFFF, 0, 0, 0, 2'b00, 1, 40'h00_FFFE_0001, -1);

    // A clear pulse during MUL must be dropped; the next op starts in the done cycle.
    run_op(16'h0007, 16'h0009, 0, 0, 0, 2'b00, 1, 40'd63, 5);
    run_op(16'h0005, 16'h0006, 0, 0, 0, 2'b01, 1, 40'd93, -1);
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("no_queued_start", 64'(extra), 0);

    run_op(16'h0000, 16'h0000, 0, 0, 0, 2'b11, 1, 40'h0, -1);
    for (int i = 0; i < 600; i++)
      run_op(16'h7FFF, 16'h7FFF, 1, 0, 0, 2'b01, 0, 40'h0, -1);
    check("mac_mv", 64'(mv), 1);
    if (SAT) check("mac_mr", 64'(mr_out), 64'h7F_FFFF_FFFF);
    else     check("mac_mr", 64'(mr_out), (64'd600 * 64'h3FFF_0001) & 64'hFF_FFFF_FFFF);

    op_a = 16'd3; op_b = 16'd3; ps_mul_sgn = 1'b0; ps_mul_IbF = 1'b0;
    ps_mul_rndPrdt = 1'b0; ps_mul_op = 2'b01; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 0);
    check("abort_done", 64'(done), 0);
    check("abort_mv", 64'(mv), 0);
    check("abort_mr", 64'(mr_out), 0);
    m_mr = 0;
    m_mv = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'd2, 16'd2, 0, 0, 0, 2'b00, 1, 40'd4, -1);

    for (int i = 0; i < 300; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_op(pick(), pick(), 1'($urandom), 1'($urandom), 1'($urandom), rop, 0, 40'h0, -1);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
